// File: rtl/dmem_arbiter_if.sv
// Request/response and RAM-side signal bundle for dmem_arbiter.
// The slave side is the arbiter. The master side is the requesters plus the data RAM.
interface dmem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        busy;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_op;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, op0, op1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, busy,
           mem_en, mem_we, mem_addr, mem_wdata, mem_op
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, op0, op1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, busy,
           mem_en, mem_we, mem_addr, mem_wdata, mem_op
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter that serialises access to one single-port data RAM.
// It applies alignment checks, and it returns read data RD_LAT cycles after issue.
module dmem_arbiter #(
  parameter int unsigned RD_LAT    = 1,  // 1..7
  parameter bit          PRIO_MODE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        win_q, win_d;
  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [2:0]  lat_op_q, lat_op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;

  logic        w;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_op;

  // Sizes 000/100 take any address, 001/101 need halfword alignment, and 010 needs word alignment.
  function automatic logic op_legal(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: op_legal = 1'b1;
      3'b001, 3'b101: op_legal = ~a[0];
      3'b010:         op_legal = (a == 2'b00);
      default:        op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_op_d     = lat_op_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;

    if (PRIO_MODE)                w = ~bus.req0;
    else if (bus.req0 && bus.req1) w = ~last_grant_q;
    else                          w = bus.req1;

    sel_we    = w ? bus.we1    : bus.we0;
    sel_addr  = w ? bus.addr1  : bus.addr0;
    sel_wdata = w ? bus.wdata1 : bus.wdata0;
    sel_op    = w ? bus.op1    : bus.op0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d       = w;
          lat_we_d    = sel_we;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          lat_op_d    = sel_op;
          if (op_legal(sel_op, sel_addr[1:0])) begin
            // The strobes are registered here so that they are high for exactly the ISSUE cycle.
            state_d  = ISSUE;
            gnt0_d   = ~w;
            gnt1_d   = w;
            mem_en_d = 1'b1;
            mem_we_d = sel_we;
          end else begin
            err0_d = ~w;
            err1_d = w;
          end
        end
      end
      ISSUE: begin
        last_grant_d = win_q;
        if (lat_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'd1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(RD_LAT)) begin
          state_d = IDLE;
          if (win_q) begin
            rdata1_d  = bus.mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = bus.mem_rdata;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment only, so every flop samples its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_op_q     <= '0;
      cnt_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_op_q     <= lat_op_d;
      cnt_q        <= cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = lat_addr_q;
  assign bus.mem_wdata = lat_wdata_q;
  assign bus.mem_op    = lat_op_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Three configurations share one stimulus stream:
// round-robin with RD_LAT=2, fixed priority with RD_LAT=1, and round-robin with RD_LAT=3.
module tb_dmem_arbiter;
  localparam int RR = 0, FP = 1, L3 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic [2:0]  op0 = 0, op1 = 0;

  logic [2:0]  gnt0_v, gnt1_v, err0_v, err1_v, rvalid0_v, rvalid1_v, busy_v, mem_en_v, mem_we_v;
  logic [31:0] mem_addr_v [3];
  logic [31:0] mem_wdata_v[3];
  logic [31:0] rdata1_v   [3];

  int n_checks = 0;
  int n_err    = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter_if bus ();
    assign bus.req0 = req0;   assign bus.req1 = req1;
    assign bus.we0 = we0;     assign bus.we1 = we1;
    assign bus.addr0 = addr0; assign bus.addr1 = addr1;
    assign bus.wdata0 = wdata0; assign bus.wdata1 = wdata1;
    assign bus.op0 = op0;     assign bus.op1 = op1;
    assign bus.mem_rdata = mem_rdata;
    assign gnt0_v[g] = bus.gnt0;       assign gnt1_v[g] = bus.gnt1;
    assign err0_v[g] = bus.err0;       assign err1_v[g] = bus.err1;
    assign rvalid0_v[g] = bus.rvalid0; assign rvalid1_v[g] = bus.rvalid1;
    assign busy_v[g] = bus.busy;       assign mem_en_v[g] = bus.mem_en;
    assign mem_we_v[g] = bus.mem_we;   assign mem_addr_v[g] = bus.mem_addr;
    assign mem_wdata_v[g] = bus.mem_wdata;
    assign rdata1_v[g] = bus.rdata1;

    dmem_arbiter #(
      .RD_LAT    ((g == 0) ? 2 : (g == 1) ? 1 : 3),
      .PRIO_MODE ((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",   {29'd0, busy_v},   32'd0);
    check("rst_gnt0",   {29'd0, gnt0_v},   32'd0);
    check("rst_mem_en", {29'd0, mem_en_v}, 32'd0);
    check("rst_addr",   mem_addr_v[RR],    32'd0);
    check("rst_rdata1", rdata1_v[RR],      32'd0);

    // Requester 0 writes; the grant and the RAM strobe appear one cycle later.
    req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF; op0 = 3'b010;
    tick();
    check("wr_gnt0",   gnt0_v[RR],     1'b1);
    check("wr_gnt1",   gnt1_v[RR],     1'b0);
    check("wr_mem_en", mem_en_v[RR],   1'b1);
    check("wr_mem_we", mem_we_v[RR],   1'b1);
    check("wr_addr",   mem_addr_v[RR], 32'h100);
    check("wr_wdata",  mem_wdata_v[RR], 32'hDEADBEEF);
    req0 = 0;
    tick();
    check("wr_busy_lo", busy_v[RR],   1'b0);
    check("wr_en_lo",   mem_en_v[RR], 1'b0);

    // Requester 1 reads. RR returns data at T+4, and L3 returns data at T+5.
    req1 = 1; we1 = 0; addr1 = 32'h104; op1 = 3'b010;
    tick();
    check("rd_gnt1",   gnt1_v[RR],     1'b1);
    check("rd_mem_we", mem_we_v[RR],   1'b0);
    check("rd_addr",   mem_addr_v[RR], 32'h104);
    req1 = 0;
    tick();
    check("rd_busy_t2", busy_v[RR], 1'b1);
    tick();
    mem_rdata = 32'h12345678;
    check("rd_no_early_rvalid", rvalid1_v[RR], 1'b0);
    tick();
    mem_rdata = 32'hFFFFFFFF;
    check("rd_rvalid1", rvalid1_v[RR], 1'b1);
    check("rd_rdata1",  rdata1_v[RR],  32'h12345678);
    check("rd_idle",    busy_v[RR],    1'b0);
    tick();
    mem_rdata = 32'h0;
    check("rd_rvalid_pulse", rvalid1_v[RR], 1'b0);
    check("rd_rdata_hold",   rdata1_v[RR],  32'h12345678);
    check("l3_rvalid1",      rvalid1_v[L3], 1'b1);
    check("l3_rdata1",       rdata1_v[L3],  32'hFFFFFFFF);

    // Both requesters hold writes: RR alternates 0,1,0,1, and FP always grants requester 0.
    req0 = 1; we0 = 1; addr0 = 32'h200; op0 = 3'b010;
    req1 = 1; we1 = 1; addr1 = 32'h300; op1 = 3'b010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_gnt0_%0d", k), gnt0_v[RR], (k % 2 == 0));
      check($sformatf("rr_gnt1_%0d", k), gnt1_v[RR], (k % 2 == 1));
      check($sformatf("fp_gnt0_%0d", k), gnt0_v[FP], 1'b1);
      check($sformatf("fp_gnt1_%0d", k), gnt1_v[FP], 1'b0);
      tick();
      check($sformatf("rr_gap_%0d", k), {gnt1_v[RR], gnt0_v[RR]}, 2'b00);
    end
    req0 = 0;
    tick();
    check("fp_gnt1_after_drop", gnt1_v[FP], 1'b1);
    check("fp_gnt0_after_drop", gnt0_v[FP], 1'b0);
    req1 = 0;
    tick();

    // An illegal request pulses err0 and issues nothing to the RAM.
    req0 = 1; we0 = 0; op0 = 3'b001; addr0 = 32'h3;
    tick();
    check("mis_err0",   err0_v[RR],   1'b1);
    check("mis_mem_en", mem_en_v[RR], 1'b0);
    check("mis_gnt0",   gnt0_v[RR],   1'b0);
    check("mis_busy",   busy_v[RR],   1'b0);
    op0 = 3'b011; addr0 = 32'h0;
    tick();
    check("ill_err0",   err0_v[RR],   1'b1);
    check("ill_mem_en", mem_en_v[RR], 1'b0);
    req0 = 0;
    tick();
    check("err_pulse", err0_v[RR], 1'b0);
    // RR last served requester 1, so requester 0 still wins the tie.
    req0 = 1; we0 = 1; op0 = 3'b010; addr0 = 32'h10;
    req1 = 1; we1 = 1; op1 = 3'b010; addr1 = 32'h20;
    tick();
    check("lg_kept_gnt0", gnt0_v[RR], 1'b1);
    check("lg_kept_gnt1", gnt1_v[RR], 1'b0);
    req0 = 0; req1 = 0;
    tick();

    // L3 read is aborted by a reset in its second WAIT cycle.
    req1 = 1; we1 = 0; addr1 = 32'h44; op1 = 3'b010;
    tick();
    check("l3_gnt1", gnt1_v[L3], 1'b1);
    req1 = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   busy_v[L3],    1'b0);
    check("abort_rvalid", rvalid1_v[L3], 1'b0);
    check("abort_rdata",  rdata1_v[L3],  32'h0);
    check("abort_mem_en", mem_en_v[L3],  1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort_no_rvalid_%0d", k), rvalid1_v[L3], 1'b0);
    end

    // A fresh read after the reset completes normally.
    req1 = 1; we1 = 0; addr1 = 32'h48; op1 = 3'b010;
    tick();
    check("post_gnt1", gnt1_v[L3], 1'b1);
    check("post_addr", mem_addr_v[L3], 32'h48);
    req1 = 0;
    tick();
    tick();
    tick();
    mem_rdata = 32'hCAFEF00D;
    check("post_no_early", rvalid1_v[L3], 1'b0);
    tick();
    mem_rdata = 32'h0;
    check("post_rvalid1", rvalid1_v[L3], 1'b1);
    check("post_rdata1",  rdata1_v[L3],  32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares one single-port data RAM between the core load/store port (requester 0) and a DMA/program-loader port (requester 1).
- Sits between rv_go_core's mem_op/mem_w/alu_result/data_to_ram signals and the data RAM.
- Serialises accesses, applies round-robin or fixed priority, checks alignment and returns read data with a valid pulse after a configurable RAM read latency.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from mem_en to mem_rdata valid; legal range 1..7.
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 wins.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0 / req1  input  1  access request; held with its fields stable until gnt_x or err_x
- we0 / we1  input  1  1 = store, 0 = load
- addr0 / addr1  input  32  byte address
- wdata0 / wdata1  input  32  store data
- op0 / op1  input  3  RV funct3 size code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- gnt0 / gnt1  output  1  one-cycle pulse; request accepted and issued this cycle
- rvalid0 / rvalid1  output  1  one-cycle pulse; rdata_x valid
- rdata0 / rdata1  output  32  read data; holds its value until the next read for that port completes
- err0 / err1  output  1  one-cycle pulse; misaligned or illegal op rejected, nothing issued
- busy  output  1  state != IDLE
- mem_en  output  1  RAM access strobe
- mem_we  output  1  RAM write enable, qualified by mem_en
- mem_addr  output  32  RAM address
- mem_wdata  output  32  RAM write data
- mem_op  output  3  size code passed through to the RAM
- mem_rdata  input  32  RAM read data, valid RD_LAT cycles after mem_en

Behaviour:
- Reset values: state = IDLE; last_grant = 1, so requester 0 wins the first round-robin tie.
- Every other output, and rdata0/1, resets to 0.
- States:
  - IDLE: sample req0/req1.
  - ISSUE: exactly one cycle.
  - WAIT: RD_LAT cycles, reads only.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests: select a winner W.
  - PRIO_MODE=1: W = 0 if req0, else 1.
  - PRIO_MODE=0 with both requesting: W = !last_grant.
  - Latch W's fields.
  - Alignment check on the latched fields. Illegal: op ∉ {000,001,010,100,101}; halfword with addr[0]=1; word with addr[1:0]!=0.
  - If illegal: next cycle err_W=1, stay in IDLE, last_grant unchanged.
  - If legal: go to ISSUE.
- ISSUE:
  - mem_en=1; mem_we, mem_addr, mem_wdata, mem_op come from the latch; gnt_W=1.
  - last_grant <= W.
  - Write: next state is IDLE.
  - Read: next state is WAIT; cnt <= 1.
- WAIT:
  - cnt increments each cycle.
  - When cnt == RD_LAT, capture mem_rdata into rdata_W and go to IDLE.
  - On the following cycle rvalid_W=1.
- Timing, request sampled in IDLE at cycle T:
  - gnt at T+1.
  - A write lets the next request be sampled at T+2.
  - A read gives rvalid at T+2+RD_LAT; that cycle is IDLE, so a new request may be sampled in the same cycle.
- Outside ISSUE: mem_en=0, mem_we=0; address/data outputs are don't-care but stable.
- Requests arriving while busy are ignored until IDLE; a requester must keep req high. A deasserted req is never retro-granted.
- The requester drops req after gnt or err. If req is still high in the cycle after gnt (IDLE), it is treated as a new request.
- rst during ISSUE or WAIT:
  - Next cycle is IDLE with all outputs at reset values.
  - No rvalid or gnt is produced for the aborted access.
  - A write issued in ISSUE still reached the RAM that cycle.
- Only one of gnt0/gnt1/err0/err1/rvalid0/rvalid1 fires per requester per cycle. gnt0 and gnt1 are never high together.

Test Plan:
- Write on requester 0: addr0=0x100, wdata0=0xDEADBEEF, op0=010, we0=1 → gnt0 at T+1 with mem_en=1, mem_we=1, mem_addr=0x100; busy low at T+2.
- Read with RD_LAT=2: req1, addr1=0x104, op1=010, RAM drives 0x12345678 at T+3 → gnt1 at T+1; rvalid1 and rdata1=0x12345678 at T+4; rdata1 still 0x12345678 afterwards.
- Round-robin: req0 and req1 held high continuously for 4 writes → grant order 0,1,0,1; no gnt gap beyond one IDLE cycle between grants.
- PRIO_MODE=1: same continuous stimulus → gnt0 every access, gnt1 never; drop req0 → gnt1 on the next arbitration.
- Misaligned: req0 with op0=001 and addr0=0x3, then op0=011 → err0 pulse each time, mem_en stays 0, last_grant unchanged.
- Reset mid-read, RD_LAT=3: assert rst in the second WAIT cycle → state IDLE, rvalid never pulses, rdata=0; a new read after reset completes normally.
